sev_seg_scan_ctrl: RTL

//  MMIO-programmable scan controller for the 8-digit 7-segment display peripheral.

---
 rtl/sev_seg_pkg.sv | 41 ++++
 rtl/sev_seg_prescale.sv | 41 ++++
 rtl/sev_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sev_seg_pkg.sv
// Shared definitions for the 7-segment scan controller: register offsets,
// CTRL field positions, reset constants, scan index type and nibble helpers.
package sev_seg_pkg;

    localparam int unsigned OFF_DATA   = 0;
    localparam int unsigned OFF_CTRL   = 4;
    localparam int unsigned OFF_STATUS = 8;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_LZB_BIT   = 1;
    localparam int unsigned CTRL_MASK_LSB  = 8;
    localparam int unsigned CTRL_BLINK_LSB = 16;

    localparam logic       CTRL_EN_RST   = 1'b1;
    localparam logic       CTRL_LZB_RST  = 1'b0;
    localparam logic [7:0] CTRL_MASK_RST = 8'hFF;

    typedef enum logic [2:0] {
        DIG0 = 3'd0,
        DIG1 = 3'd1,
        DIG2 = 3'd2,
        DIG3 = 3'd3,
        DIG4 = 3'd4,
        DIG5 = 3'd5,
        DIG6 = 3'd6,
        DIG7 = 3'd7
    } scan_idx_e;

    // Nibble belonging to digit i of a 32-bit display word.
    function automatic logic [3:0] nib_of(input logic [31:0] d, input logic [2:0] i);
        logic [31:0] sh;
        sh = d >> {i, 2'b00};
        return sh[3:0];
    endfunction

    // True when digit i and every more-significant digit are zero.
    function automatic logic upper_zero(input logic [31:0] d, input logic [2:0] i);
        return ((d >> {i, 2'b00}) == 32'd0);
    endfunction

endpackage

// File: rtl/sev_seg_prescale.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and raises tick_o for one cycle
// at terminal count. hold_i freezes the count (display disabled).
module sev_seg_prescale #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    output logic tick_o
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and terminal-count tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (hold_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == TERM) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// 8-digit 7-segment scan controller with MMIO register window.
// DATA writes land in a shadow buffer that is committed to the displayed
// (active) buffer when the scan wraps from digit 7 to digit 0.
// Optional feature macro: SEV_SEG_CTRL_BLINK_EN (CTRL[23:16] blink mask).
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rd_valid,
    output logic [7:0]        an_out,
    output logic [3:0]        seg_nib,
    output logic              seg_blank
);

    logic [31:0] shadow_q, shadow_d;
    logic [31:0] active_q, active_d;
    logic        en_q, en_d;
    logic        lzb_q, lzb_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  blink_q, blink_d;
    scan_idx_e   idx_q, idx_d;
    logic [7:0]  an_q, an_d;
    logic [3:0]  nib_q, nib_d;
    logic        blank_q, blank_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_valid_q;
    logic        tick_s;
    logic [7:0]  mask_eff_s;
    logic        sel_data_s, sel_ctrl_s, sel_status_s;
    logic [31:0] rd_val_s;

    sev_seg_prescale #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescale (
        .clk    (clk),
        .rst    (rst),
        .hold_i (~en_q),
        .tick_o (tick_s)
    );

`ifdef SEV_SEG_CTRL_BLINK_EN
    logic [23:0] blink_cnt_q;
    logic        phase_q;

    // Free-running blink counter; phase flips each time it wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= 24'd0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 24'd1;
            if (blink_cnt_q == 24'hFF_FFFF) begin
                phase_q <= ~phase_q;
            end else begin
                phase_q <= phase_q;
            end
        end
    end

    assign mask_eff_s = mask_q & ~(blink_q & {8{phase_q}});
`else
    assign mask_eff_s = mask_q;
`endif

    // Register writes, frame commit, scan advance, display outputs, readback.
    always_comb begin
        sel_data_s   = (addr == ADDR_W'(OFF_DATA));
        sel_ctrl_s   = (addr == ADDR_W'(OFF_CTRL));
        sel_status_s = (addr == ADDR_W'(OFF_STATUS));

        shadow_d = shadow_q;
        en_d     = en_q;
        lzb_d    = lzb_q;
        mask_d   = mask_q;
        blink_d  = blink_q;
        active_d = active_q;
        idx_d    = idx_q;
        an_d     = an_q;
        nib_d    = nib_q;
        blank_d  = blank_q;
        rd_val_s = 32'd0;
        rdata_d  = 32'd0;

        if (wr_en && sel_data_s) begin
            shadow_d = wdata;
        end else begin
            shadow_d = shadow_q;
        end

        if (wr_en && sel_ctrl_s) begin
            en_d   = wdata[CTRL_EN_BIT];
            lzb_d  = wdata[CTRL_LZB_BIT];
            mask_d = wdata[CTRL_MASK_LSB +: 8];
`ifdef SEV_SEG_CTRL_BLINK_EN
            blink_d = wdata[CTRL_BLINK_LSB +: 8];
`else
            blink_d = 8'h00;
`endif
        end else begin
            en_d    = en_q;
            lzb_d   = lzb_q;
            mask_d  = mask_q;
            blink_d = blink_q;
        end

        // shadow_d already carries a same-cycle DATA write, so it lands in
        // active without waiting a further frame.
        if (tick_s && (idx_q == DIG7)) begin
            active_d = shadow_d;
        end else begin
            active_d = active_q;
        end

        if (tick_s) begin
            idx_d = scan_idx_e'(idx_q + 3'd1);
        end else begin
            idx_d = idx_q;
        end

        if (!en_q) begin
            an_d    = 8'hFF;
            blank_d = 1'b1;
        end else if (tick_s) begin
            nib_d = nib_of(active_d, idx_d);
            if (!mask_eff_s[idx_d]) begin
                an_d    = 8'hFF;
                blank_d = 1'b1;
            end else begin
                an_d    = ~(8'b1 << idx_d);
                blank_d = lzb_q && (idx_d != DIG0) && upper_zero(active_d, idx_d);
            end
        end else begin
            an_d    = an_q;
            blank_d = blank_q;
        end

        if (sel_data_s) begin
            rd_val_s = shadow_d;
        end else if (sel_ctrl_s) begin
            rd_val_s = {8'h00, blink_d, mask_d, 6'd0, lzb_d, en_d};
        end else if (sel_status_s) begin
            rd_val_s = {23'd0, (shadow_q != active_q), 5'd0, idx_q};
        end else begin
            rd_val_s = 32'd0;
        end

        if (rd_en) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= 32'd0;
            active_q   <= 32'd0;
            en_q       <= CTRL_EN_RST;
            lzb_q      <= CTRL_LZB_RST;
            mask_q     <= CTRL_MASK_RST;
            blink_q    <= 8'h00;
            idx_q      <= DIG0;
            an_q       <= 8'hFF;
            nib_q      <= 4'd0;
            blank_q    <= 1'b1;
            rdata_q    <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            en_q       <= en_d;
            lzb_q      <= lzb_d;
            mask_q     <= mask_d;
            blink_q    <= blink_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            nib_q      <= nib_d;
            blank_q    <= blank_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rdata     = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign an_out    = an_q;
    assign seg_nib   = nib_q;
    assign seg_blank = blank_q;

endmodule
